// File: rtl/ram_sync_param_if.sv
// Request/response bundle for ram_sync_param.
// Latency: none. This file only groups the signals.
// Backpressure: none. busy tells the requester that its requests are being dropped.
// Ports (master = requester, slave = RAM):
//   write_enable, read_enable, addr, write_data : master -> slave
//   read_data, read_valid, busy                  : slave -> master
interface ram_sync_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  write_enable;
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  busy;

  modport master (
    output write_enable, read_enable, addr, write_data,
    input  read_data, read_valid, busy
  );

  modport slave (
    input  write_enable, read_enable, addr, write_data,
    output read_data, read_valid, busy
  );
endinterface

// File: rtl/ram_sync_param.sv
// Single-port synchronous scratch RAM, DATA_WIDTH x 2**ADDR_WIDTH, hardware-cleared after reset.
// Latency: a read issued at edge N shows read_data/read_valid in cycle N+1. Writes land at the edge.
// Backpressure: none. While busy (clear running) every request is silently dropped.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : write_enable/read_enable/addr/write_data in; read_data/read_valid/busy out
module ram_sync_param #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    RDW_MODE    = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic            clock,
  input  logic            reset,
  ram_sync_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] clr_cnt_nxt;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_go;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] read_q;
  logic                  valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // The clear sequencer owns the memory write port while in CLEAR; user
  // requests are only honoured once READY.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    mem_we      = 1'b0;
    mem_waddr   = bus.addr;
    mem_wdata   = bus.write_data;
    rd_go       = 1'b0;
    case (state)
      CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clr_cnt;
        mem_wdata   = CLEAR_VALUE;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
          state_nxt = READY;
        end
      end
      READY: begin
        mem_we = bus.write_enable;
        rd_go  = bus.read_enable;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // Storage has no reset; holding reset leaves contents untouched.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Same-address read+write: the array read already returns the old word
  // (read-first); write-first bypasses the incoming data instead.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_go;
      if (rd_go) begin
        read_q <= ((RDW_MODE != 0) && bus.write_enable) ? bus.write_data : mem[bus.addr];
      end
    end
  end

  assign bus.read_data  = read_q;
  assign bus.read_valid = valid_q;
  assign bus.busy       = (state == CLEAR);
endmodule

// File: tb/tb_ram_sync_param.sv
// Bench for ram_sync_param: two instances (read-first/clear 0x00, write-first/clear 0x3C)
// share one stimulus stream; a word-array model is compared against both every cycle,
// with directed sequences carrying literal expectations followed by a randomized phase.
module tb_ram_sync_param;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam logic [7:0] CV0 = 8'h00;
  localparam logic [7:0] CV1 = 8'h3C;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic we = 1'b0;
  logic re = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wd = '0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ram_sync_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  ram_sync_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  assign bus0.write_enable = we;
  assign bus0.read_enable  = re;
  assign bus0.addr         = addr;
  assign bus0.write_data   = wd;
  assign bus1.write_enable = we;
  assign bus1.read_enable  = re;
  assign bus1.addr         = addr;
  assign bus1.write_data   = wd;

  ram_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .CLEAR_VALUE(CV0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0.slave));
  ram_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .CLEAR_VALUE(CV1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each reset (re)fills the word arrays with the clear value,
  // since nothing is observable until the clear finishes; then DEPTH idle cycles of busy.
  logic [DW-1:0] m0 [DEPTH];
  logic [DW-1:0] m1 [DEPTH];
  int   busy_left   = 0;
  bit   model_valid = 1'b0;
  logic exp_busy = 1'b1;
  logic exp_vld  = 1'b0;
  logic [DW-1:0] exp_rd0 = '0;
  logic [DW-1:0] exp_rd1 = '0;

  always @(posedge clock) begin
    if (reset) begin
      model_valid = 1'b1;
      busy_left   = DEPTH;
      exp_vld     = 1'b0;
      exp_rd0     = '0;
      exp_rd1     = '0;
      for (int i = 0; i < DEPTH; i++) begin
        m0[i] = CV0;
        m1[i] = CV1;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      exp_vld = 1'b0;
    end else begin
      exp_vld = re;
      if (re) begin
        exp_rd0 = m0[addr];
        exp_rd1 = we ? wd : m1[addr];
      end
      if (we) begin
        m0[addr] = wd;
        m1[addr] = wd;
      end
    end
    exp_busy = reset || (busy_left > 0);
  end

  always @(negedge clock) begin
    if (model_valid) begin
      chk("busy0", 32'(bus0.busy), 32'(exp_busy));
      chk("busy1", 32'(bus1.busy), 32'(exp_busy));
      chk("valid0", 32'(bus0.read_valid), 32'(exp_vld));
      chk("valid1", 32'(bus1.read_valid), 32'(exp_vld));
      chk("rdata0", 32'(bus0.read_data), 32'(exp_rd0));
      chk("rdata1", 32'(bus1.read_data), 32'(exp_rd1));
    end
  end

  // Present one request, let one edge consume it, return just after the edge.
  task automatic step(input logic w, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = w; re = r; addr = a; wd = d;
    @(posedge clock);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  // Counts cycles with busy high, from now until it drops (bounded).
  task automatic count_busy(output int n);
    n = 0;
    while (bus0.busy && n < 40) begin
      n++;
      step(1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic expect_read(input string nm, input logic [7:0] e0, input logic [7:0] e1);
    chk({nm, "_valid"}, 32'(bus0.read_valid), 32'd1);
    chk({nm, "_d0"}, 32'(bus0.read_data), 32'(e0));
    chk({nm, "_d1"}, 32'(bus1.read_data), 32'(e1));
    chk({nm, "_model"}, 32'(exp_rd0), 32'(e0));
  endtask

  initial begin
    int n;
    // 1: reset two cycles, then the clear runs for exactly DEPTH cycles.
    reset = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset_busy", 32'(bus0.busy), 32'd1);
    chk("reset_rdata", 32'(bus0.read_data), 32'd0);
    chk("reset_valid", 32'(bus1.read_valid), 32'd0);
    reset = 1'b0;
    count_busy(n);
    chk("clear_len", 32'(n), 32'd16);

    // 2: every word holds the clear value.
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, AW'(i), 0);
      expect_read("cleared", 8'h00, 8'h3C);
    end

    // 3: basic write then read; top and bottom addresses.
    step(1, 0, 4'd3, 8'hA5);
    step(0, 1, 4'd3, 0);
    expect_read("rd3", 8'hA5, 8'hA5);
    step(0, 0, 0, 0);
    chk("valid_drop", 32'(bus0.read_valid), 32'd0);
    chk("rdata_hold", 32'(bus0.read_data), 32'hA5);
    step(1, 0, 4'd15, 8'h5A);
    step(0, 1, 4'd15, 0);
    expect_read("rd15", 8'h5A, 8'h5A);
    step(0, 1, 4'd0, 0);
    expect_read("rd0", 8'h00, 8'h3C);

    // 4: same-address read+write.
    step(1, 0, 4'd7, 8'h11);
    step(1, 1, 4'd7, 8'h22);
    expect_read("rdw", 8'h11, 8'h22);
    step(0, 1, 4'd7, 0);
    expect_read("rdw_after", 8'h22, 8'h22);

    // 5: requests during clear are dropped.
    reset = 1'b1;
    step(0, 1, 4'd2, 0);
    chk("rst_read_valid", 32'(bus0.read_valid), 32'd0);
    reset = 1'b0;
    step(1, 1, 4'd2, 8'hFF);
    chk("busy_read_valid", 32'(bus0.read_valid), 32'd0);
    chk("busy_rdata", 32'(bus0.read_data), 32'd0);
    count_busy(n);
    step(0, 1, 4'd2, 0);
    expect_read("rd2", 8'h00, 8'h3C);

    // 6: reset again mid-clear restarts the full sequence.
    step(1, 0, 4'd4, 8'h77);
    reset = 1'b1;
    step(0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0, 0);
    reset = 1'b0;
    count_busy(n);
    chk("reclear_len", 32'(n), 32'd16);
    step(0, 1, 4'd4, 0);
    expect_read("rd4", 8'h00, 8'h3C);

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      step(1'($urandom), 1'($urandom), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
    end
    reset = 1'b0;
    step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
